// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response and RAM-port signal bundle for dmem_arbiter
//
// Groups the bus signals of dmem_arbiter. clk and rst are not part of the bundle.
//   c_*    : core load/store unit requester (req valid/ready, rsp valid/ready)
//   d_*    : DMA / program loader requester (same signal set as c_*)
//   m_*    : single RAM port (enables, address, data, size, sign mode, read data)
//   busy   : arbiter is in the middle of a transaction
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters + RAM)
interface dmem_arbiter_if;
    logic        c_req_valid;
    logic        c_req_ready;
    logic        c_req_write;
    logic [31:0] c_req_addr;
    logic [31:0] c_req_wdata;
    logic [1:0]  c_req_size;
    logic        c_req_unsigned;
    logic        c_rsp_valid;
    logic        c_rsp_ready;
    logic [31:0] c_rsp_rdata;
    logic        c_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_write;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [1:0]  d_req_size;
    logic        d_req_unsigned;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;

    logic        m_en_write;
    logic        m_en_read;
    logic [31:0] m_addr;
    logic [31:0] m_din;
    logic [1:0]  m_size;
    logic        m_unsigned;
    logic [31:0] m_dout;

    logic        busy;

    modport slave (
        input  c_req_valid, c_req_write, c_req_addr, c_req_wdata, c_req_size, c_req_unsigned,
        output c_req_ready,
        output c_rsp_valid, c_rsp_rdata, c_rsp_err,
        input  c_rsp_ready,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_size, d_req_unsigned,
        output d_req_ready,
        output d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  d_rsp_ready,
        output m_en_write, m_en_read, m_addr, m_din, m_size, m_unsigned,
        input  m_dout,
        output busy
    );

    modport master (
        output c_req_valid, c_req_write, c_req_addr, c_req_wdata, c_req_size, c_req_unsigned,
        input  c_req_ready,
        input  c_rsp_valid, c_rsp_rdata, c_rsp_err,
        output c_rsp_ready,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_size, d_req_unsigned,
        input  d_req_ready,
        input  d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output d_rsp_ready,
        input  m_en_write, m_en_read, m_addr, m_din, m_size, m_unsigned,
        output m_dout,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter and sequencer for one data RAM port
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave - core (c_*) and DMA (d_*) request/response
//          handshakes, the RAM port (m_*) and the busy flag
// Parameters:
//   MEM_BYTES : addressable bytes; addresses at or above this return an error
//
// One transaction is outstanding at a time: IDLE -> ISSUE -> CAPTURE -> RESP,
// or IDLE -> RESP directly for a request that fails the alignment/range checks.
module dmem_arbiter #(
    parameter int MEM_BYTES = 4096
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state;
    logic        last_grant_d;   // 1: DMA won the last grant, so the core wins the next tie
    logic        owner_d;        // owner of the transaction in flight
    logic        write_q;

    logic        c_rsp_valid_q, d_rsp_valid_q;
    logic        c_rsp_err_q,   d_rsp_err_q;
    logic [31:0] c_rsp_rdata_q, d_rsp_rdata_q;

    // The m_* registers double as the latched request: they are loaded at
    // acceptance and only held while in ISSUE, so they read 0 everywhere else.
    logic        m_en_write_q, m_en_read_q, m_unsigned_q;
    logic [31:0] m_addr_q, m_din_q;
    logic [1:0]  m_size_q;
    logic        busy_q;

    logic        grant_c, grant_d, accept, req_err, rsp_done;
    logic        sel_write, sel_unsigned;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size;

    always_comb begin
        grant_c = bus.c_req_valid && (!bus.d_req_valid || last_grant_d);
        grant_d = bus.d_req_valid && !grant_c;
        accept  = (state == IDLE) && (grant_c || grant_d);

        sel_write    = grant_d ? bus.d_req_write    : bus.c_req_write;
        sel_addr     = grant_d ? bus.d_req_addr     : bus.c_req_addr;
        sel_wdata    = grant_d ? bus.d_req_wdata    : bus.c_req_wdata;
        sel_size     = grant_d ? bus.d_req_size     : bus.c_req_size;
        sel_unsigned = grant_d ? bus.d_req_unsigned : bus.c_req_unsigned;

        req_err = (sel_size == 2'b11)
               || (sel_size == 2'b01 && sel_addr[0])
               || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)
               || (sel_addr >= MEM_LIMIT);

        rsp_done = owner_d ? (d_rsp_valid_q && bus.d_rsp_ready)
                           : (c_rsp_valid_q && bus.c_rsp_ready);
    end

    assign bus.c_req_ready = (state == IDLE) && grant_c;
    assign bus.d_req_ready = (state == IDLE) && grant_d;

    assign bus.c_rsp_valid = c_rsp_valid_q;
    assign bus.c_rsp_err   = c_rsp_err_q;
    assign bus.c_rsp_rdata = c_rsp_rdata_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_err   = d_rsp_err_q;
    assign bus.d_rsp_rdata = d_rsp_rdata_q;

    assign bus.m_en_write = m_en_write_q;
    assign bus.m_en_read  = m_en_read_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_din      = m_din_q;
    assign bus.m_size     = m_size_q;
    assign bus.m_unsigned = m_unsigned_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant_d  <= 1'b1;
            owner_d       <= 1'b0;
            write_q       <= 1'b0;
            c_rsp_valid_q <= 1'b0;
            c_rsp_err_q   <= 1'b0;
            c_rsp_rdata_q <= '0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_err_q   <= 1'b0;
            d_rsp_rdata_q <= '0;
            m_en_write_q  <= 1'b0;
            m_en_read_q   <= 1'b0;
            m_addr_q      <= '0;
            m_din_q       <= '0;
            m_size_q      <= '0;
            m_unsigned_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_d      <= grant_d;
                        last_grant_d <= grant_d;
                        write_q      <= sel_write;
                        busy_q       <= 1'b1;
                        if (req_err) begin
                            // Rejected requests never touch the RAM.
                            state <= RESP;
                            if (grant_d) begin
                                d_rsp_valid_q <= 1'b1;
                                d_rsp_err_q   <= 1'b1;
                                d_rsp_rdata_q <= '0;
                            end else begin
                                c_rsp_valid_q <= 1'b1;
                                c_rsp_err_q   <= 1'b1;
                                c_rsp_rdata_q <= '0;
                            end
                        end else begin
                            state        <= ISSUE;
                            m_en_write_q <= sel_write;
                            m_en_read_q  <= !sel_write;
                            m_addr_q     <= sel_addr;
                            m_din_q      <= sel_write ? sel_wdata : 32'h0;
                            m_size_q     <= sel_size;
                            m_unsigned_q <= sel_unsigned;
                        end
                    end
                end
                ISSUE: begin
                    state        <= CAPTURE;
                    m_en_write_q <= 1'b0;
                    m_en_read_q  <= 1'b0;
                    m_addr_q     <= '0;
                    m_din_q      <= '0;
                    m_size_q     <= '0;
                    m_unsigned_q <= 1'b0;
                end
                CAPTURE: begin
                    // The RAM registers its output, so m_dout is valid now.
                    state <= RESP;
                    if (owner_d) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_err_q   <= 1'b0;
                        d_rsp_rdata_q <= write_q ? 32'h0 : bus.m_dout;
                    end else begin
                        c_rsp_valid_q <= 1'b1;
                        c_rsp_err_q   <= 1'b0;
                        c_rsp_rdata_q <= write_q ? 32'h0 : bus.m_dout;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        state         <= IDLE;
                        busy_q        <= 1'b0;
                        c_rsp_valid_q <= 1'b0;
                        c_rsp_err_q   <= 1'b0;
                        c_rsp_rdata_q <= '0;
                        d_rsp_valid_q <= 1'b0;
                        d_rsp_err_q   <= 1'b0;
                        d_rsp_rdata_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter #(.MEM_BYTES(4096)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = w >> {a[1:0], 3'b000};
        case (sz)
            2'b00:   return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ram_wr(input logic [31:0] old, input logic [31:0] din,
                                           input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh = {a[1:0], 3'b000};
        case (sz)
            2'b00:   mask = 32'h0000_00FF << sh;
            2'b01:   mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | ((din << sh) & mask);
    endfunction

    // RAM model: registered read, seeded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[4]    <= 32'h1234_5678;
            mem[5]    <= 32'hCAFE_F00D;
            mem[1023] <= 32'hA5A5_A5A5;
            bus.m_dout <= 32'h0;
        end else begin
            if (bus.m_en_write) begin
                wr_cnt <= wr_cnt + 1;
                mem[bus.m_addr[11:2]] <= ram_wr(mem[bus.m_addr[11:2]], bus.m_din, bus.m_addr, bus.m_size);
            end
            if (bus.m_en_read)
                bus.m_dout <= ram_rd(mem[bus.m_addr[11:2]], bus.m_addr, bus.m_size, bus.m_unsigned);
        end
    end

    task automatic pop_cmp(input logic port, input logic [31:0] rd, input logic er);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: port %0d rdata 0x%08h err %0d, no response expected", port, rd, er);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_owner", {31'h0, port}, {31'h0, e.owner});
            chk("rsp_rdata", rd, e.rdata);
            chk("rsp_err", {31'h0, er}, {31'h0, e.err});
        end
    endtask

    // Monitor: compares every response handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("one_rsp_at_a_time", {31'h0, bus.c_rsp_valid & bus.d_rsp_valid}, 32'h0);
            if (bus.c_rsp_valid && bus.c_rsp_ready) pop_cmp(1'b0, bus.c_rsp_rdata, bus.c_rsp_err);
            if (bus.d_rsp_valid && bus.d_rsp_ready) pop_cmp(1'b1, bus.d_rsp_rdata, bus.d_rsp_err);
        end
    end

    // Drives one request and waits for acceptance; waited counts negedges until ready.
    task automatic issue(input logic port, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rdata, input logic exp_err, input logic push,
                         output int waited);
        logic got;
        if (!port) begin
            bus.c_req_valid = 1'b1; bus.c_req_write = wr; bus.c_req_addr = addr;
            bus.c_req_wdata = wdata; bus.c_req_size = size; bus.c_req_unsigned = uns;
        end else begin
            bus.d_req_valid = 1'b1; bus.d_req_write = wr; bus.d_req_addr = addr;
            bus.d_req_wdata = wdata; bus.d_req_size = size; bus.d_req_unsigned = uns;
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 30) begin
            @(negedge clk);
            waited++;
            got = port ? bus.d_req_ready : bus.c_req_ready;
        end
        if (got) begin
            if (push) exp_q.push_back('{port, exp_rdata, exp_err});
        end else begin
            chk("accept_timeout", 32'h0, 32'h1);
        end
        @(posedge clk);
        #1;
        if (!port) bus.c_req_valid = 1'b0;
        else       bus.d_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((bus.busy || exp_q.size() != 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_reached", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Both ports present word loads continuously; grants must alternate starting with C.
    task automatic contend(input int n, input logic [31:0] ca, input logic [31:0] cexp,
                           input logic [31:0] da, input logic [31:0] dexp);
        int got = 0;
        int cyc = 0;
        bus.c_req_valid = 1'b1; bus.c_req_write = 1'b0; bus.c_req_addr = ca;
        bus.c_req_size = 2'b10; bus.c_req_unsigned = 1'b0;
        bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = da;
        bus.d_req_size = 2'b10; bus.d_req_unsigned = 1'b0;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.c_req_ready || bus.d_req_ready) begin
                chk("single_grant", {31'h0, bus.c_req_ready & bus.d_req_ready}, 32'h0);
                chk("grant_order", {31'h0, bus.d_req_ready}, 32'(got & 1));
                if (bus.d_req_ready) exp_q.push_back('{1'b1, dexp, 1'b0});
                else                 exp_q.push_back('{1'b0, cexp, 1'b0});
                got++;
            end
        end
        chk("contend_accepts", 32'(got), 32'(n));
        @(posedge clk);
        #1;
        bus.c_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
    endtask

    initial begin
        int w;
        int wr_snap;
        int cyc;
        rst = 1'b1;
        bus.c_req_valid = 0; bus.c_req_write = 0; bus.c_req_addr = 0; bus.c_req_wdata = 0;
        bus.c_req_size = 0;  bus.c_req_unsigned = 0; bus.c_rsp_ready = 1;
        bus.d_req_valid = 0; bus.d_req_write = 0; bus.d_req_addr = 0; bus.d_req_wdata = 0;
        bus.d_req_size = 0;  bus.d_req_unsigned = 0; bus.d_rsp_ready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_c_rsp_valid", {31'h0, bus.c_rsp_valid}, 32'h0);
        chk("rst_d_rsp_valid", {31'h0, bus.d_rsp_valid}, 32'h0);
        chk("rst_c_rsp_rdata", bus.c_rsp_rdata, 32'h0);
        chk("rst_m_en", {30'h0, bus.m_en_write, bus.m_en_read}, 32'h0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention from reset: C, D, C, D.
        contend(4, 32'h10, 32'h1234_5678, 32'h14, 32'hCAFE_F00D);
        wait_idle();

        // Core load word: latency and one-cycle read enable.
        issue(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 1'b1, w);
        @(negedge clk);
        chk("lw_issue_en_read", {31'h0, bus.m_en_read}, 32'h1);
        chk("lw_issue_en_write", {31'h0, bus.m_en_write}, 32'h0);
        chk("lw_issue_addr", bus.m_addr, 32'h10);
        chk("lw_issue_size", {30'h0, bus.m_size}, 32'h2);
        chk("lw_busy", {31'h0, bus.busy}, 32'h1);
        @(negedge clk);
        chk("lw_capture_en_read", {31'h0, bus.m_en_read}, 32'h0);
        chk("lw_capture_rsp_valid", {31'h0, bus.c_rsp_valid}, 32'h0);
        @(negedge clk);
        chk("lw_rsp_valid_n3", {31'h0, bus.c_rsp_valid}, 32'h1);
        chk("lw_d_rsp_quiet", {31'h0, bus.d_rsp_valid}, 32'h0);
        wait_idle();

        // Sub-word loads exercising size and sign passthrough.
        issue(1'b0, 1'b0, 32'h17, 32'h0, 2'b00, 1'b0, 32'hFFFF_FFCA, 1'b0, 1'b1, w); wait_idle();
        issue(1'b0, 1'b0, 32'h16, 32'h0, 2'b01, 1'b1, 32'h0000_CAFE, 1'b0, 1'b1, w); wait_idle();
        issue(1'b1, 1'b0, 32'h14, 32'h0, 2'b01, 1'b0, 32'hFFFF_F00D, 1'b0, 1'b1, w); wait_idle();
        issue(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h0000_0012, 1'b0, 1'b1, w); wait_idle();
        issue(1'b0, 1'b1, 32'h41, 32'h0000_00AB, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, w); wait_idle();
        issue(1'b0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h0000_AB00, 1'b0, 1'b1, w); wait_idle();
        issue(1'b0, 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b1, w); wait_idle();

        // Error cases: RAM untouched, response one cycle after acceptance.
        wr_snap = wr_cnt;
        issue(1'b1, 1'b1, 32'h3, 32'h5555, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1, w);
        @(negedge clk);
        chk("err_rsp_n1", {31'h0, bus.d_rsp_valid}, 32'h1);
        chk("err_no_write", {31'h0, bus.m_en_write}, 32'h0);
        wait_idle();
        issue(1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1'b1, w); wait_idle();
        issue(1'b0, 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, w); wait_idle();
        issue(1'b0, 1'b0, 32'h2, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, w); wait_idle();
        chk("err_wr_count", 32'(wr_cnt), 32'(wr_snap));

        // Back-pressure on the core response while D waits.
        bus.c_rsp_ready = 1'b0;
        issue(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, w);
        bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 32'h20;
        bus.d_req_size = 2'b10; bus.d_req_unsigned = 1'b0;
        cyc = 0;
        while (!bus.c_rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_rsp_arrived", {31'h0, bus.c_rsp_valid}, 32'h1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", {31'h0, bus.c_rsp_valid}, 32'h1);
            chk("bp_rdata_held", bus.c_rsp_rdata, 32'h0);
            chk("bp_err_held", {31'h0, bus.c_rsp_err}, 32'h0);
            chk("bp_d_stalled", {31'h0, bus.d_req_ready}, 32'h0);
        end
        @(posedge clk);
        #1 bus.c_rsp_ready = 1'b1;
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, w);
        chk("bp_d_granted_after_hs", 32'(w), 32'd2);
        wait_idle();

        // Reset during ISSUE of a store.
        wr_snap = wr_cnt;
        issue(1'b0, 1'b1, 32'h30, 32'h1111_1111, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, w);
        #1;
        chk("rst_mid_en_write_before", {31'h0, bus.m_en_write}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_en_write_async", {31'h0, bus.m_en_write}, 32'h0);
        chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", {31'h0, bus.c_rsp_valid | bus.d_rsp_valid}, 32'h0);
        end
        chk("rst_mid_no_ram_write", 32'(wr_cnt), 32'(wr_snap));
        @(posedge clk);
        #1;
        contend(2, 32'h30, 32'h0, 32'h14, 32'hCAFE_F00D);
        wait_idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
